// File: rtl/lock_operator.sv
// Automatic operator sequencer for the canal lock controller.
// Queues gondola arrival/departure requests and walks the lock through one
// complete passage at a time: equalise, open entry gate, close, raise/lower,
// open exit gate, close. All outputs are registered and decoded from the
// next state, so they line up with the state register every cycle.
module lock_operator #(
    parameter int LOW_TH      = 3,
    parameter int HIGH_TH     = 47,
    parameter int GATE_CYCLES = 8,
    parameter int TIMEOUT     = 4000,
    parameter int TO_W        = 12
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       arrive_req,
    input  logic       depart_req,
    input  logic       clear_fault,
    input  logic [5:0] waterLevel,
    input  logic       upperGate,
    input  logic       lowerGate,
    input  logic       occupied,
    output logic       arriving,
    output logic       departing,
    output logic       upperSwitch,
    output logic       lowerSwitch,
    output logic       waterUp,
    output logic       waterDown,
    output logic       busy,
    output logic       done,
    output logic       fault,
    output logic       overflow,
    output logic [7:0] passages,
    output logic [2:0] pend_arr,
    output logic [2:0] pend_dep
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_SEEK      = 3'd1,
        S_OPEN_IN   = 3'd2,
        S_CLOSE_IN  = 3'd3,
        S_MOVE      = 3'd4,
        S_OPEN_OUT  = 3'd5,
        S_CLOSE_OUT = 3'd6,
        S_FAULT     = 3'd7
    } state_t;

    typedef enum logic {
        DIR_ARR = 1'b0,
        DIR_DEP = 1'b1
    } dir_t;

    localparam int              GC_W      = $clog2(GATE_CYCLES + 1);
    localparam logic [5:0]      LOW_LVL   = 6'(LOW_TH);
    localparam logic [5:0]      HIGH_LVL  = 6'(HIGH_TH);
    localparam logic [GC_W-1:0] GATE_LAST = GC_W'(GATE_CYCLES - 1);
    localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT);
    localparam logic [2:0]      PEND_MAX  = 3'd7;

    // State and bookkeeping registers
    state_t          state_q, state_d;
    dir_t            dir_q, dir_d;
    logic [TO_W-1:0] timer_q, timer_d;
    logic [GC_W-1:0] gate_cnt_q, gate_cnt_d;
    logic [2:0]      pend_arr_q, pend_arr_d;
    logic [2:0]      pend_dep_q, pend_dep_d;
    logic [7:0]      passages_q, passages_d;

    // Registered output copies
    logic arriving_q, arriving_d;
    logic departing_q, departing_d;
    logic upper_sw_q, upper_sw_d;
    logic lower_sw_q, lower_sw_d;
    logic water_up_q, water_up_d;
    logic water_dn_q, water_dn_d;
    logic busy_q, busy_d;
    logic done_q, done_d;
    logic fault_q, fault_d;
    logic overflow_q, overflow_d;

    // Internal strobes
    logic grant_arr_s, grant_dep_s, pass_done_s;
    logic ovf_arr_s, ovf_dep_s;
    logic entry_fb_s, exit_fb_s;
    logic level_in_ok_s, level_out_ok_s;
    logic active_s;

    // Entry gate is the lower one when rising, the upper one when descending
    always_comb begin
        if (dir_q == DIR_ARR) begin
            entry_fb_s     = lowerGate;
            exit_fb_s      = upperGate;
            level_in_ok_s  = (waterLevel <= LOW_LVL);
            level_out_ok_s = (waterLevel >= HIGH_LVL);
        end else begin
            entry_fb_s     = upperGate;
            exit_fb_s      = lowerGate;
            level_in_ok_s  = (waterLevel >= HIGH_LVL);
            level_out_ok_s = (waterLevel <= LOW_LVL);
        end
    end

    // Passage sequencing, gate counting and watchdog override
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        gate_cnt_d  = gate_cnt_q;
        grant_arr_s = 1'b0;
        grant_dep_s = 1'b0;
        pass_done_s = 1'b0;
        active_s    = (state_q != S_IDLE) && (state_q != S_FAULT);
        case (state_q)
            S_IDLE: begin
                if ((pend_arr_q != 3'd0) &&
                    ((pend_dep_q == 3'd0) || (dir_q == DIR_DEP))) begin
                    dir_d       = DIR_ARR;
                    grant_arr_s = 1'b1;
                    state_d     = S_SEEK;
                end else if (pend_dep_q != 3'd0) begin
                    dir_d       = DIR_DEP;
                    grant_dep_s = 1'b1;
                    state_d     = S_SEEK;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SEEK: begin
                if (level_in_ok_s) begin
                    state_d = S_OPEN_IN;
                end else begin
                    state_d = S_SEEK;
                end
            end
            S_OPEN_IN: begin
                if (entry_fb_s) begin
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d = S_CLOSE_IN;
                    end else begin
                        gate_cnt_d = gate_cnt_q + GC_W'(1);
                    end
                end else begin
                    gate_cnt_d = gate_cnt_q;
                end
            end
            S_CLOSE_IN: begin
                if (!entry_fb_s && occupied) begin
                    state_d = S_MOVE;
                end else begin
                    state_d = S_CLOSE_IN;
                end
            end
            S_MOVE: begin
                if (level_out_ok_s) begin
                    state_d = S_OPEN_OUT;
                end else begin
                    state_d = S_MOVE;
                end
            end
            S_OPEN_OUT: begin
                if (exit_fb_s) begin
                    if (gate_cnt_q == GATE_LAST) begin
                        state_d = S_CLOSE_OUT;
                    end else begin
                        gate_cnt_d = gate_cnt_q + GC_W'(1);
                    end
                end else begin
                    gate_cnt_d = gate_cnt_q;
                end
            end
            S_CLOSE_OUT: begin
                if (!exit_fb_s && !occupied) begin
                    state_d     = S_IDLE;
                    pass_done_s = 1'b1;
                end else begin
                    state_d = S_CLOSE_OUT;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_d = S_IDLE;
                end else begin
                    state_d = S_FAULT;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // A stuck passage is abandoned; a completion on the same edge does not count
        if (active_s && (timer_q == TO_LIMIT)) begin
            state_d     = S_FAULT;
            pass_done_s = 1'b0;
        end else begin
            pass_done_s = pass_done_s;
        end
        if (state_d != state_q) begin
            gate_cnt_d = {GC_W{1'b0}};
        end else begin
            gate_cnt_d = gate_cnt_d;
        end
    end

    // Watchdog timer restarts on every state change and idles outside a passage
    always_comb begin
        if (state_d != state_q) begin
            timer_d = {TO_W{1'b0}};
        end else if (active_s) begin
            timer_d = timer_q + TO_W'(1);
        end else begin
            timer_d = {TO_W{1'b0}};
        end
    end

    // Request queues: saturate at 7, simultaneous request and grant cancel out
    always_comb begin
        ovf_arr_s = 1'b0;
        ovf_dep_s = 1'b0;
        if (arrive_req && grant_arr_s) begin
            pend_arr_d = pend_arr_q;
        end else if (arrive_req) begin
            if (pend_arr_q == PEND_MAX) begin
                pend_arr_d = pend_arr_q;
                ovf_arr_s  = 1'b1;
            end else begin
                pend_arr_d = pend_arr_q + 3'd1;
            end
        end else if (grant_arr_s) begin
            pend_arr_d = pend_arr_q - 3'd1;
        end else begin
            pend_arr_d = pend_arr_q;
        end
        if (depart_req && grant_dep_s) begin
            pend_dep_d = pend_dep_q;
        end else if (depart_req) begin
            if (pend_dep_q == PEND_MAX) begin
                pend_dep_d = pend_dep_q;
                ovf_dep_s  = 1'b1;
            end else begin
                pend_dep_d = pend_dep_q + 3'd1;
            end
        end else if (grant_dep_s) begin
            pend_dep_d = pend_dep_q - 3'd1;
        end else begin
            pend_dep_d = pend_dep_q;
        end
        if (pass_done_s) begin
            passages_d = passages_q + 8'd1;
        end else begin
            passages_d = passages_q;
        end
    end

    // Moore output decode from the upcoming state and direction
    always_comb begin
        arriving_d  = 1'b0;
        departing_d = 1'b0;
        upper_sw_d  = 1'b0;
        lower_sw_d  = 1'b0;
        water_up_d  = 1'b0;
        water_dn_d  = 1'b0;
        case (state_d)
            S_SEEK, S_CLOSE_IN: begin
                arriving_d  = (dir_d == DIR_ARR);
                departing_d = (dir_d == DIR_DEP);
            end
            S_OPEN_IN: begin
                arriving_d  = (dir_d == DIR_ARR);
                departing_d = (dir_d == DIR_DEP);
                lower_sw_d  = (dir_d == DIR_ARR);
                upper_sw_d  = (dir_d == DIR_DEP);
            end
            S_MOVE: begin
                water_up_d = (dir_d == DIR_ARR);
                water_dn_d = (dir_d == DIR_DEP);
            end
            S_OPEN_OUT: begin
                upper_sw_d = (dir_d == DIR_ARR);
                lower_sw_d = (dir_d == DIR_DEP);
            end
            default: begin
                arriving_d = 1'b0;
            end
        endcase
        busy_d     = (state_d != S_IDLE) && (state_d != S_FAULT);
        fault_d    = (state_d == S_FAULT);
        done_d     = pass_done_s;
        overflow_d = ovf_arr_s | ovf_dep_s;
    end

    // State, counters and registered outputs
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= S_IDLE;
            dir_q       <= DIR_DEP;
            timer_q     <= {TO_W{1'b0}};
            gate_cnt_q  <= {GC_W{1'b0}};
            pend_arr_q  <= 3'd0;
            pend_dep_q  <= 3'd0;
            passages_q  <= 8'd0;
            arriving_q  <= 1'b0;
            departing_q <= 1'b0;
            upper_sw_q  <= 1'b0;
            lower_sw_q  <= 1'b0;
            water_up_q  <= 1'b0;
            water_dn_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fault_q     <= 1'b0;
            overflow_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            dir_q       <= dir_d;
            timer_q     <= timer_d;
            gate_cnt_q  <= gate_cnt_d;
            pend_arr_q  <= pend_arr_d;
            pend_dep_q  <= pend_dep_d;
            passages_q  <= passages_d;
            arriving_q  <= arriving_d;
            departing_q <= departing_d;
            upper_sw_q  <= upper_sw_d;
            lower_sw_q  <= lower_sw_d;
            water_up_q  <= water_up_d;
            water_dn_q  <= water_dn_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            fault_q     <= fault_d;
            overflow_q  <= overflow_d;
        end
    end

    assign arriving    = arriving_q;
    assign departing   = departing_q;
    assign upperSwitch = upper_sw_q;
    assign lowerSwitch = lower_sw_q;
    assign waterUp     = water_up_q;
    assign waterDown   = water_dn_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign fault       = fault_q;
    assign overflow    = overflow_q;
    assign passages    = passages_q;
    assign pend_arr    = pend_arr_q;
    assign pend_dep    = pend_dep_q;

endmodule

// File: tb/tb_lock_operator.sv
// Bench for lock_operator: a table of hand-driven cycle vectors for one
// passage, then sequences against a simple lock model (level, gate delay,
// occupancy) for queueing, saturation, watchdog fault and async reset.
module tb_lock_operator;

    logic       Clock, Reset;
    logic       arrive_req, depart_req, clear_fault;
    logic [5:0] waterLevel;
    logic       upperGate, lowerGate, occupied;
    logic       arriving, departing, upperSwitch, lowerSwitch, waterUp, waterDown;
    logic       busy, done, fault, overflow;
    logic [7:0] passages;
    logic [2:0] pend_arr, pend_dep;

    lock_operator dut (
        .Clock(Clock), .Reset(Reset),
        .arrive_req(arrive_req), .depart_req(depart_req), .clear_fault(clear_fault),
        .waterLevel(waterLevel), .upperGate(upperGate), .lowerGate(lowerGate),
        .occupied(occupied),
        .arriving(arriving), .departing(departing),
        .upperSwitch(upperSwitch), .lowerSwitch(lowerSwitch),
        .waterUp(waterUp), .waterDown(waterDown),
        .busy(busy), .done(done), .fault(fault), .overflow(overflow),
        .passages(passages), .pend_arr(pend_arr), .pend_dep(pend_dep)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    typedef struct {
        logic       arr, dep, clr;
        logic [5:0] lvl;
        logic       ug, lg, occ;
        int         reps;
        logic [5:0] e_lock;   // arriving,departing,upperSw,lowerSw,waterUp,waterDown
        logic [3:0] e_st;     // busy,done,fault,overflow
        logic [7:0] e_pass;
        logic [2:0] e_pa, e_pd;
    } vec_t;

    vec_t tbl [17];

    int total = 0;
    int bad   = 0;
    int inv_bad = 0;

    // lock model state
    bit   model_en = 1'b0;
    bit   lg_stuck = 1'b0;
    logic prev_up = 1'b0, prev_lo = 1'b0;
    int   s_lo_fb, s_up_fb, s_wup, s_wdn, s_done, s_lo_on;

    function automatic logic [23:0] snap();
        return {arriving, departing, upperSwitch, lowerSwitch, waterUp, waterDown,
                busy, done, fault, overflow, passages, pend_arr, pend_dep};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic clear_stats();
        s_lo_fb = 0; s_up_fb = 0; s_wup = 0; s_wdn = 0; s_done = 0; s_lo_on = 0;
    endtask

    task automatic reset_model();
        upperGate = 1'b0; lowerGate = 1'b0; occupied = 1'b0;
        prev_up = 1'b0; prev_lo = 1'b0;
    endtask

    // One clock; outputs sampled on the falling edge, then the model reacts
    task automatic tick();
        @(posedge Clock);
        @(negedge Clock);
        if (upperSwitch && lowerSwitch) inv_bad++;
        if (waterUp && waterDown) inv_bad++;
        if (model_en) begin
            if (waterUp && waterLevel < 6'd50) waterLevel = waterLevel + 6'd1;
            else if (waterDown && waterLevel > 6'd0) waterLevel = waterLevel - 6'd1;
            else if (arriving && waterLevel > 6'd0) waterLevel = waterLevel - 6'd1;
            else if (departing && waterLevel < 6'd50) waterLevel = waterLevel + 6'd1;
            else waterLevel = waterLevel;
            upperGate = prev_up;
            lowerGate = lg_stuck ? 1'b0 : prev_lo;
            if ((prev_up && !upperSwitch) || (prev_lo && !lowerSwitch)) occupied = ~occupied;
            prev_up = upperSwitch;
            prev_lo = lowerSwitch;
        end
        if (lowerSwitch && lowerGate) s_lo_fb++;
        if (upperSwitch && upperGate) s_up_fb++;
        if (lowerSwitch) s_lo_on++;
        if (waterUp) s_wup++;
        if (waterDown) s_wdn++;
        if (done) s_done++;
    endtask

    task automatic run_passage(input int budget, output bit ok);
        clear_stats();
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            tick();
            if (done) ok = 1'b1;
        end
    endtask

    task automatic do_reset();
        Reset = 1'b0;
        @(negedge Clock);
        @(negedge Clock);
        Reset = 1'b1;
    endtask

    initial begin
        bit ok;
        bit found;
        logic [23:0] got;

        //           arr  dep  clr  lvl    ug   lg   occ  reps lock       st       pass pa    pd
        tbl[0]  = '{1'b1,1'b0,1'b0,6'd25,1'b0,1'b0,1'b0,1,6'b000000,4'b0000,8'd0,3'd1,3'd0};
        tbl[1]  = '{1'b0,1'b0,1'b0,6'd25,1'b0,1'b0,1'b0,1,6'b100000,4'b1000,8'd0,3'd0,3'd0};
        tbl[2]  = '{1'b0,1'b0,1'b0,6'd25,1'b0,1'b1,1'b0,3,6'b100000,4'b1000,8'd0,3'd0,3'd0};
        tbl[3]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b0,1'b0,1,6'b100100,4'b1000,8'd0,3'd0,3'd0};
        tbl[4]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b0,1'b0,5,6'b100100,4'b1000,8'd0,3'd0,3'd0};
        tbl[5]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b1,1'b0,7,6'b100100,4'b1000,8'd0,3'd0,3'd0};
        tbl[6]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b1,1'b0,1,6'b100000,4'b1000,8'd0,3'd0,3'd0};
        tbl[7]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b1,1'b1,2,6'b100000,4'b1000,8'd0,3'd0,3'd0};
        tbl[8]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b0,1'b0,2,6'b100000,4'b1000,8'd0,3'd0,3'd0};
        tbl[9]  = '{1'b0,1'b0,1'b0,6'd3, 1'b0,1'b0,1'b1,1,6'b000010,4'b1000,8'd0,3'd0,3'd0};
        tbl[10] = '{1'b0,1'b1,1'b0,6'd46,1'b0,1'b0,1'b1,2,6'b000010,4'b1000,8'd0,3'd0,3'd1};
        tbl[11] = '{1'b0,1'b0,1'b0,6'd47,1'b0,1'b0,1'b1,1,6'b001000,4'b1000,8'd0,3'd0,3'd1};
        tbl[12] = '{1'b0,1'b0,1'b0,6'd47,1'b1,1'b1,1'b1,8,6'b000000,4'b1000,8'd0,3'd0,3'd1};
        tbl[13] = '{1'b0,1'b0,1'b0,6'd47,1'b0,1'b0,1'b1,2,6'b000000,4'b1000,8'd0,3'd0,3'd1};
        tbl[14] = '{1'b0,1'b0,1'b0,6'd47,1'b0,1'b0,1'b0,1,6'b000000,4'b0100,8'd1,3'd0,3'd1};
        tbl[15] = '{1'b0,1'b0,1'b0,6'd47,1'b0,1'b0,1'b0,1,6'b010000,4'b1000,8'd1,3'd0,3'd0};
        tbl[16] = '{1'b0,1'b0,1'b0,6'd47,1'b0,1'b0,1'b0,1,6'b011000,4'b1000,8'd1,3'd0,3'd0};

        arrive_req = 1'b0; depart_req = 1'b0; clear_fault = 1'b0;
        waterLevel = 6'd25;
        reset_model();
        clear_stats();
        Reset = 1'b0;
        @(negedge Clock);
        check("in_reset", 32'(snap()), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        tick();
        check("after_reset_idle", 32'(snap()), 32'd0);

        // hand-driven passage, one vector per row
        for (int r = 0; r < 17; r++) begin
            arrive_req = tbl[r].arr; depart_req = tbl[r].dep; clear_fault = tbl[r].clr;
            waterLevel = tbl[r].lvl; upperGate = tbl[r].ug; lowerGate = tbl[r].lg;
            occupied = tbl[r].occ;
            tick();
            arrive_req = 1'b0; depart_req = 1'b0; clear_fault = 1'b0;
            for (int k = 1; k < tbl[r].reps; k++) tick();
            check($sformatf("row%0d", r), 32'(snap()),
                  32'({tbl[r].e_lock, tbl[r].e_st, tbl[r].e_pass, tbl[r].e_pa, tbl[r].e_pd}));
        end

        // simultaneous requests from reset: arrival first, then departure
        reset_model();
        do_reset();
        waterLevel = 6'd25;
        model_en = 1'b1;
        arrive_req = 1'b1; depart_req = 1'b1;
        tick();
        arrive_req = 1'b0; depart_req = 1'b0;
        check("both_pend", 32'({pend_arr, pend_dep}), 32'({3'd1, 3'd1}));
        run_passage(2000, ok);
        check("pass1_ok", 32'(ok), 32'd1);
        check("pass1_up_only", 32'({s_wup > 0, s_wdn == 0}), 32'b11);
        check("pass1_gate_cycles", 32'({8'(s_lo_fb), 8'(s_up_fb)}), 32'h0808);
        check("pass1_level", 32'(waterLevel), 32'd47);
        run_passage(2000, ok);
        check("pass2_ok", 32'(ok), 32'd1);
        check("pass2_down_only", 32'({s_wdn > 0, s_wup == 0}), 32'b11);
        check("pass2_level_occ", 32'({waterLevel, occupied}), 32'({6'd3, 1'b0}));
        check("pass2_count", 32'(passages), 32'd2);

        // single arrival from mid level
        waterLevel = 6'd25;
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        run_passage(2000, ok);
        tick();
        check("arr_ok", 32'(ok), 32'd1);
        check("arr_gate_cycles", 32'({8'(s_lo_fb), 8'(s_up_fb)}), 32'h0808);
        check("arr_done_once", 32'(s_done), 32'd1);
        check("arr_end", 32'({passages, waterLevel, occupied}), 32'({8'd3, 6'd47, 1'b0}));

        // saturation of the arrival queue while busy
        waterLevel = 6'd40;
        arrive_req = 1'b1;
        tick();
        arrive_req = 1'b0;
        tick();
        check("sat_granted", 32'({busy, pend_arr}), 32'({1'b1, 3'd0}));
        for (int i = 1; i <= 9; i++) begin
            arrive_req = 1'b1;
            tick();
            arrive_req = 1'b0;
            check($sformatf("sat_pend%0d", i), 32'(pend_arr), (i < 7) ? 32'(i) : 32'd7);
            check($sformatf("sat_ovf%0d", i), 32'(overflow), (i >= 8) ? 32'd1 : 32'd0);
        end
        tick();
        check("sat_after", 32'({overflow, pend_arr}), 32'({1'b0, 3'd7}));
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            tick();
            if (waterUp) found = 1'b1;
        end
        check("sat_reach_move", 32'(found), 32'd1);
        lg_stuck = 1'b1;
        run_passage(2000, ok);
        check("sat_pass_ok", 32'({ok, passages}), 32'({1'b1, 8'd4}));

        // next arrival sticks in OPEN_IN with no lower gate feedback
        clear_stats();
        found = 1'b0;
        for (int i = 0; i < 6000 && !found; i++) begin
            tick();
            if (fault) found = 1'b1;
        end
        check("to_fault", 32'(found), 32'd1);
        check("to_cycles", 32'(s_lo_on), 32'd4001);
        check("to_state", 32'(snap()), 32'({6'b000000, 4'b0010, 8'd4, 3'd6, 3'd0}));
        depart_req = 1'b1;
        tick();
        depart_req = 1'b0;
        check("fault_queue", 32'({fault, pend_dep}), 32'({1'b1, 3'd1}));
        clear_fault = 1'b1;
        lg_stuck = 1'b0;
        reset_model();
        tick();
        clear_fault = 1'b0;
        check("clear_idle", 32'(snap()), 32'({6'b000000, 4'b0000, 8'd4, 3'd6, 3'd1}));
        tick();
        check("alt_dep", 32'(snap()), 32'({6'b010000, 4'b1000, 8'd4, 3'd6, 3'd0}));

        // asynchronous reset while raising
        found = 1'b0;
        for (int i = 0; i < 3000 && !found; i++) begin
            tick();
            if (waterUp) found = 1'b1;
        end
        check("rst_reach_move", 32'(found), 32'd1);
        #2;
        Reset = 1'b0;
        #1;
        got = snap();
        check("rst_async", 32'(got), 32'd0);
        @(negedge Clock);
        Reset = 1'b1;
        model_en = 1'b0;
        tick();
        check("rst_stays_idle", 32'(snap()), 32'd0);

        check("invariants", 32'(inv_bad), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lock_operator.md
Name: lock_operator

Overview:
- Automatic operator sequencer: drives the operator-side inputs of the canal lock controller (arriving, departing, gate switches, waterUp/waterDown) and observes its outputs plus the water-level sensor.
- Queues gondola arrival/departure requests and runs one complete passage at a time: equalise, open entry gate, close, raise/lower, open exit gate, close.
- Sits between the request buttons/sensors and the lock controller on the DE1 top level.

Parameters:
- LOW_TH, 3, water level (tenths of ft) at or below which the lower gate may open.
- HIGH_TH, 47, water level at or above which the upper gate may open.
- GATE_CYCLES, 8, cycles the opened gate's feedback must be high before the switch is released.
- TIMEOUT, 4000, cycles allowed in any non-IDLE state before FAULT.
- TO_W, 12, width of the timeout counter.

Ports:
- Clock  in  1  system clock.
- Reset  in  1  asynchronous, active-low reset.
- arrive_req  in  1  one-cycle pulse: gondola waiting below, wants to rise.
- depart_req  in  1  one-cycle pulse: gondola waiting above, wants to descend.
- clear_fault  in  1  pulse: leave FAULT.
- waterLevel  in  6  sensor level, 0..50.
- upperGate  in  1  upper gate feedback from lock.
- lowerGate  in  1  lower gate feedback from lock.
- occupied  in  1  lock occupied indicator.
- arriving  out  1  to lock.
- departing  out  1  to lock.
- upperSwitch  out  1  to lock.
- lowerSwitch  out  1  to lock.
- waterUp  out  1  to lock.
- waterDown  out  1  to lock.
- busy  out  1  high in any state except IDLE and FAULT.
- done  out  1  one-cycle pulse per completed passage.
- fault  out  1  high in FAULT.
- overflow  out  1  one-cycle pulse when a request is dropped.
- passages  out  8  completed-passage count, wraps 255->0.
- pend_arr  out  3  queued arrivals.
- pend_dep  out  3  queued departures.

Behaviour:

Outputs and reset:
- All outputs are registered (Moore, decoded from the state register).
- Reset (async, active-low) forces:
  - state IDLE;
  - all outputs 0;
  - passages, pending counters and timer 0;
  - dir = DEP, so the first grant goes to an arrival.

Pending counters:
- Saturate at 7; a request arriving at 7 is dropped and overflow pulses.
- Increment and grant-decrement in the same cycle: count unchanged.

States (dir = ARR or DEP, latched at grant):

IDLE
- If pend_arr>0 and (pend_dep==0 or last dir==DEP): dir=ARR.
- Else if pend_dep>0: dir=DEP.
- On grant, decrement the chosen counter and go to SEEK. Strict alternation applies when both are pending.

SEEK
- arriving (ARR) / departing (DEP) = 1.
- Wait for waterLevel<=LOW_TH (ARR) / >=HIGH_TH (DEP), then go to OPEN_IN.
- The lock drains/fills itself here; this block drives no water control.

OPEN_IN
- Request held; entry switch = 1 (lowerSwitch for ARR, upperSwitch for DEP).
- A gate counter counts only cycles with the matching gate feedback high; at GATE_CYCLES go to CLOSE_IN.

CLOSE_IN
- Request held; entry switch = 0.
- When entry gate feedback = 0 and occupied = 1, go to MOVE.

MOVE
- arriving/departing = 0.
- waterUp = 1 (ARR) / waterDown = 1 (DEP) until level >=HIGH_TH (ARR) / <=LOW_TH (DEP), then go to OPEN_OUT.
- waterUp and waterDown are never both 1.

OPEN_OUT
- Exit switch = 1 (upperSwitch for ARR, lowerSwitch for DEP).
- Count GATE_CYCLES of feedback high, then go to CLOSE_OUT.

CLOSE_OUT
- Exit switch = 0.
- When exit gate feedback = 0 and occupied = 0, go to IDLE; passages+1 and done pulses on that transition.

FAULT
- All lock-side outputs 0; fault = 1.
- clear_fault moves to IDLE; pending counters and passages are preserved, the dropped passage is not re-queued.

Timer:
- Cleared on every state change.
- Increments each cycle in non-IDLE, non-FAULT states.
- Timer==TIMEOUT causes a transition to FAULT on the next edge, overriding any other transition.

Other rules:
- Requests are still queued while busy or in FAULT.
- At most one switch output is 1 at any time.
- Gate feedback is ignored outside the OPEN_*/CLOSE_* states.
- Reset mid-passage returns the block to IDLE immediately, with all outputs 0.

Test Plan:
- Reset low, then high with no requests -> all outputs 0, IDLE, pend_arr=pend_dep=0, passages=0.
- arrive_req pulse, level 25, lock model attached -> arriving=1 until level<=3; lowerSwitch high for 8 feedback cycles; waterUp until level>=47; upperSwitch 8 cycles; done pulse; passages=1; occupied 0 at end.
- arrive_req and depart_req in the same cycle while IDLE -> ARR served first, then DEP; passages=2; waterDown asserted only in the DEP MOVE state.
- 9 arrive_req pulses while busy -> pend_arr saturates at 7; overflow pulses twice; pend_arr never wraps.
- lowerGate tied 0 during an arrival -> FAULT after 4000 cycles in OPEN_IN; all lock-side outputs 0; clear_fault returns to IDLE with remaining pends intact.
- Reset asserted during MOVE with waterUp=1 -> waterUp=0 immediately (asynchronous), state IDLE, counters 0.
